// File: rtl/data_path_rx.sv
// Receive side of the 8-bit data_path link: undoes the transmit bit-mixing,
// buffers decoded bytes in a show-ahead FIFO and counts bytes lost to a full FIFO.
module data_path_rx #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    enc_in,
  input  logic          enc_valid_in,
  output logic [7:0]    data_out,
  output logic          valid_out,
  input  logic          ready_in,
  input  logic          clear_ovf,
  output logic          overflow,
  output logic [7:0]    drop_count,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = CW - 1;

  logic [7:0]    dec_d;
  logic [7:0]    dec_q;
  logic          dec_vld;
  logic [7:0]    mem [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          drop;

  // The upper nibble travels in the clear, so it unmixes the lower nibble.
  always_comb begin
    dec_d[7:4] = enc_in[7:4];
    for (int i = 0; i < 4; i++) begin
      dec_d[i] = ~(enc_in[i] ^ enc_in[7-i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q   <= 8'h00;
      dec_vld <= 1'b0;
    end else begin
      dec_vld <= enc_valid_in;
      if (enc_valid_in) begin
        dec_q <= dec_d;
      end
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[CW-1] != rd_ptr[CW-1]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_count = wr_ptr - rd_ptr;

  assign valid_out  = ~empty;
  assign data_out   = valid_out ? mem[rd_ptr[AW-1:0]] : 8'h00;

  assign push  = dec_vld;
  assign pop   = valid_out & ready_in;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= dec_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // A drop colliding with a clear counts as the first drop after the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= 8'h00;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_ovf) begin
        drop_count <= 8'h01;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'h01;
      end
    end else if (clear_ovf) begin
      overflow   <= 1'b0;
      drop_count <= 8'h00;
    end
  end

endmodule

// File: tb/tb_data_path_rx.sv
// Self-checking bench for data_path_rx: decode vector table, boundary sequences
// and randomized round trips against a queue-based reference model.
module tb_data_path_rx;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk;
  logic          rst_n;
  logic [7:0]    enc_in;
  logic          enc_valid_in;
  logic [7:0]    data_out;
  logic          valid_out;
  logic          ready_in;
  logic          clear_ovf;
  logic          overflow;
  logic [7:0]    drop_count;
  logic [CW-1:0] fifo_count;

  int tests_run;
  int tests_failed;

  logic [7:0] m_q[$];
  logic       m_st_vld;
  logic [7:0] m_st_data;
  logic       m_ovf;
  int         m_drop;

  typedef struct {
    logic [7:0] enc;
    logic       vld;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs[6];

  data_path_rx #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enc_in       (enc_in),
    .enc_valid_in (enc_valid_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .clear_ovf    (clear_ovf),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmit-side transform, used to build stimulus and to invert by search.
  function automatic logic [7:0] encode_ref(input logic [7:0] d);
    logic [7:0] e;
    e[7:4] = d[7:4];
    for (int i = 0; i < 4; i++) e[i] = ~(d[i] ^ d[7-i]);
    return e;
  endfunction

  function automatic logic [7:0] decode_ref(input logic [7:0] e);
    for (int d = 0; d < 256; d++) begin
      if (encode_ref(8'(d)) == e) return 8'(d);
    end
    return 8'h00;
  endfunction

  task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_q.delete();
    m_st_vld  = 1'b0;
    m_st_data = 8'h00;
    m_ovf     = 1'b0;
    m_drop    = 0;
  endtask

  // Called at a falling edge: drive inputs, advance the model by one edge,
  // and return at the next falling edge.
  task automatic applyStimulus(input logic [7:0] enc, input logic vld,
                               input logic rdy, input logic clr);
    logic do_pop;
    logic do_drop;
    enc_in       = enc;
    enc_valid_in = vld;
    ready_in     = rdy;
    clear_ovf    = clr;
    do_pop  = (m_q.size() != 0) && rdy;
    do_drop = m_st_vld && (m_q.size() == DEPTH) && !do_pop;
    if (do_pop) void'(m_q.pop_front());
    if (m_st_vld && !do_drop) m_q.push_back(m_st_data);
    if (do_drop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    m_st_vld = vld;
    if (vld) m_st_data = decode_ref(enc);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput();
    logic [7:0] exp_data;
    exp_data = (m_q.size() != 0) ? m_q[0] : 8'h00;
    checkValue("valid_out",  {7'b0, valid_out}, {7'b0, (m_q.size() != 0)});
    checkValue("data_out",   data_out, exp_data);
    checkValue("fifo_count", {5'b0, fifo_count}, 8'(m_q.size()));
    checkValue("overflow",   {7'b0, overflow}, {7'b0, m_ovf});
    checkValue("drop_count", drop_count, 8'(m_drop));
  endtask

  task automatic step(input logic [7:0] enc, input logic vld, input logic rdy, input logic clr);
    applyStimulus(enc, vld, rdy, clr);
    checkOutput();
  endtask

  task automatic doReset();
    enc_in       = 8'h00;
    enc_valid_in = 1'b0;
    ready_in     = 1'b0;
    clear_ovf    = 1'b0;
    rst_n        = 1'b0;
    modelReset();
    #1;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    enc_in       = 8'h00;
    enc_valid_in = 1'b0;
    ready_in     = 1'b0;
    clear_ovf    = 1'b0;
    modelReset();

    vecs[0] = '{8'hAF, 1'b1, 1'b1, 1'b0, 8'h00, 8'd0};
    vecs[1] = '{8'h0F, 1'b1, 1'b1, 1'b1, 8'hA5, 8'd1};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'h00, 8'd1};
    vecs[3] = '{8'h0E, 1'b1, 1'b1, 1'b1, 8'hFF, 8'd1};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 8'd1};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0};

    @(negedge clk);
    doReset();
    checkValue("rst_valid", {7'b0, valid_out}, 8'h00);
    checkValue("rst_drop",  drop_count, 8'h00);

    // Decode vectors
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].enc, vecs[i].vld, vecs[i].rdy, 1'b0);
      checkValue($sformatf("tbl%0d_valid", i), {7'b0, valid_out}, {7'b0, vecs[i].exp_valid});
      checkValue($sformatf("tbl%0d_data", i), data_out, vecs[i].exp_data);
      checkValue($sformatf("tbl%0d_count", i), {5'b0, fifo_count}, vecs[i].exp_count);
    end

    // Fill and overflow
    doReset();
    for (int i = 0; i < 6; i++) step(encode_ref(8'(i + 1)), 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    checkValue("fill_count", {5'b0, fifo_count}, 8'd4);
    checkValue("fill_ovf",   {7'b0, overflow}, 8'h01);
    checkValue("fill_drop",  drop_count, 8'd2);
    for (int i = 0; i < 4; i++) begin
      checkValue($sformatf("drain%0d", i), data_out, 8'(i + 1));
      step(8'h00, 1'b0, 1'b1, 1'b0);
    end
    checkValue("drain_empty", {7'b0, valid_out}, 8'h00);

    // Full with simultaneous pop across pointer wrap
    doReset();
    for (int i = 0; i < 4; i++) step(encode_ref(8'(8'h21 + i)), 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    step(encode_ref(8'h25), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(encode_ref(8'(8'h26 + i)), 1'b1, 1'b1, 1'b0);
      checkValue($sformatf("fullpop%0d_count", i), {5'b0, fifo_count}, 8'd4);
      checkValue($sformatf("fullpop%0d_ovf", i), {7'b0, overflow}, 8'h00);
    end
    for (int i = 0; i < 6; i++) step(8'h00, 1'b0, 1'b1, 1'b0);

    // Clear colliding with a drop, clear alone, then saturation
    doReset();
    for (int i = 0; i < 4; i++) step(encode_ref(8'(8'h11 * (i + 1))), 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    step(encode_ref(8'h55), 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    checkValue("coll_ovf",  {7'b0, overflow}, 8'h01);
    checkValue("coll_drop", drop_count, 8'h01);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    checkValue("clr_ovf",   {7'b0, overflow}, 8'h00);
    checkValue("clr_drop",  drop_count, 8'h00);
    checkValue("clr_count", {5'b0, fifo_count}, 8'd4);
    for (int i = 0; i < 300; i++) applyStimulus(8'($urandom), 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    checkValue("sat_drop", drop_count, 8'hFF);

    // Reset mid-operation: 3 buffered, one in the stage register
    step(encode_ref(8'h77), 1'b1, 1'b1, 1'b0);
    checkValue("pre_rst_count", {5'b0, fifo_count}, 8'd3);
    enc_valid_in = 1'b0;
    ready_in     = 1'b0;
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkValue("async_valid", {7'b0, valid_out}, 8'h00);
    checkValue("async_data",  data_out, 8'h00);
    checkValue("async_count", {5'b0, fifo_count}, 8'h00);
    checkValue("async_ovf",   {7'b0, overflow}, 8'h00);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    step(encode_ref(8'h99), 1'b1, 1'b0, 1'b0);
    checkValue("post_rst_lat1", {7'b0, valid_out}, 8'h00);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    checkValue("post_rst_lat2", data_out, 8'h99);

    // Round trip with the consumer always ready: no drops allowed
    doReset();
    for (int i = 0; i < 150; i++) begin
      step(encode_ref(8'($urandom)), ($urandom_range(0, 3) != 0), 1'b1, 1'b0);
    end
    checkValue("rt_no_drop", drop_count, 8'h00);

    // Random backpressure and occasional clears
    for (int i = 0; i < 300; i++) begin
      step(encode_ref(8'($urandom)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
